// File: rtl/bt656_line_packetizer.sv
// BT656 active-video line packetizer: strips timing codes and writes each active line
// into the downstream FIFO as a 4-byte header plus ACTIVE_BYTES payload, only when it fits whole.
module bt656_line_packetizer #(
  parameter int unsigned ACTIVE_BYTES = 1440,
  parameter int unsigned FREE_W       = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              err_clr,
  input  logic [7:0]        bt656_in,
  input  logic [FREE_W-1:0] fifo_free,
  output logic              fifo_wr_en,
  output logic [7:0]        fifo_wr_data,
  output logic [7:0]        frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              short_err
);

  localparam logic [FREE_W-1:0] PKT_BYTES = FREE_W'(ACTIVE_BYTES + 4);
  localparam logic [10:0]       LAST_IDX  = 11'(ACTIVE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, PAY, PAD, DROP} state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  s0_r, s1_r, s2_r, s3_r;
  logic [1:0]  hdr_idx_r, hdr_idx_nxt_s;
  logic [10:0] byte_cnt_r, byte_cnt_nxt_s;
  logic [10:0] line_cnt_r, hdr_line_r;
  logic        hdr_f_r, prev_f_r;
  logic        wr_en_r, wr_en_nxt_s;
  logic [7:0]  wr_data_r, wr_data_nxt_s;
  logic [7:0]  frame_cnt_r;
  logic [15:0] drop_cnt_r;
  logic        short_err_r;
  logic        drop_inc_s, short_set_s;

  logic win_s, code_f_s, code_v_s, code_h_s, sav_go_s, fits_s;

  assign win_s    = (s3_r == 8'hFF) && (s2_r == 8'h00) && (s1_r == 8'h00) && s0_r[7];
  assign code_f_s = s0_r[6];
  assign code_v_s = s0_r[5];
  assign code_h_s = s0_r[4];
  assign sav_go_s = win_s && !code_h_s && !code_v_s && enable;
  assign fits_s   = (fifo_free >= PKT_BYTES);

  // Next-state and write decision; DROP behaves like IDLE on the window that ends it.
  always_comb begin
    state_nxt_s    = state_r;
    wr_en_nxt_s    = 1'b0;
    wr_data_nxt_s  = 8'h00;
    byte_cnt_nxt_s = byte_cnt_r;
    hdr_idx_nxt_s  = hdr_idx_r;
    drop_inc_s     = 1'b0;
    short_set_s    = 1'b0;
    case (state_r)
      IDLE, DROP: begin
        if ((state_r == IDLE) || win_s) begin
          if (sav_go_s) begin
            if (fits_s) begin
              state_nxt_s   = HDR;
              wr_en_nxt_s   = 1'b1;
              wr_data_nxt_s = SYNC_BYTE;
              hdr_idx_nxt_s = 2'd1;
            end else begin
              state_nxt_s = DROP;
              drop_inc_s  = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DROP;
        end
      end
      HDR: begin
        wr_en_nxt_s   = 1'b1;
        hdr_idx_nxt_s = hdr_idx_r + 2'd1;
        case (hdr_idx_r)
          2'd1:    wr_data_nxt_s = frame_cnt_r;
          2'd2:    wr_data_nxt_s = {hdr_f_r, 4'b0000, hdr_line_r[10:8]};
          default: wr_data_nxt_s = hdr_line_r[7:0];
        endcase
        if (hdr_idx_r == 2'd3) begin
          state_nxt_s    = PAY;
          byte_cnt_nxt_s = 11'd0;
        end else begin
          state_nxt_s = HDR;
        end
      end
      PAY: begin
        wr_en_nxt_s    = 1'b1;
        byte_cnt_nxt_s = byte_cnt_r + 11'd1;
        if (win_s) begin
          // Premature code: keep the packet length fixed by padding with zeros.
          wr_data_nxt_s = 8'h00;
          short_set_s   = 1'b1;
          if (byte_cnt_r == LAST_IDX) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = PAD;
          end
        end else begin
          wr_data_nxt_s = s3_r;
          if (byte_cnt_r == LAST_IDX) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = PAY;
          end
        end
      end
      PAD: begin
        wr_en_nxt_s    = 1'b1;
        wr_data_nxt_s  = 8'h00;
        byte_cnt_nxt_s = byte_cnt_r + 11'd1;
        if (byte_cnt_r == LAST_IDX) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PAD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Byte pipe, FSM state and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_r       <= 8'h00;
      s1_r       <= 8'h00;
      s2_r       <= 8'h00;
      s3_r       <= 8'h00;
      state_r    <= IDLE;
      hdr_idx_r  <= 2'd0;
      byte_cnt_r <= 11'd0;
      wr_en_r    <= 1'b0;
      wr_data_r  <= 8'h00;
    end else begin
      s0_r       <= bt656_in;
      s1_r       <= s0_r;
      s2_r       <= s1_r;
      s3_r       <= s2_r;
      state_r    <= state_nxt_s;
      hdr_idx_r  <= hdr_idx_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      wr_en_r    <= wr_en_nxt_s;
      wr_data_r  <= wr_data_nxt_s;
    end
  end

  // Field/line tracking on every code window, independent of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_f_r    <= 1'b0;
      frame_cnt_r <= 8'h00;
      line_cnt_r  <= 11'd0;
      hdr_line_r  <= 11'd0;
      hdr_f_r     <= 1'b0;
    end else if (win_s) begin
      prev_f_r <= code_f_s;
      if (prev_f_r && !code_f_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      if (code_v_s) begin
        line_cnt_r <= 11'd0;
      end else if (!code_h_s) begin
        hdr_line_r <= line_cnt_r;
        hdr_f_r    <= code_f_s;
        line_cnt_r <= line_cnt_r + 11'd1;
      end
    end
  end

  // Error/status counters; err_clr overrides a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r  <= 16'h0000;
      short_err_r <= 1'b0;
    end else if (err_clr) begin
      drop_cnt_r  <= 16'h0000;
      short_err_r <= 1'b0;
    end else begin
      if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
      if (short_set_s) begin
        short_err_r <= 1'b1;
      end
    end
  end

  assign fifo_wr_en   = wr_en_r;
  assign fifo_wr_data = wr_data_r;
  assign frame_cnt    = frame_cnt_r;
  assign drop_cnt     = drop_cnt_r;
  assign short_err    = short_err_r;

endmodule
